// File: rtl/serial_add_sub_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_sub_pkg
// Shared types and constants for the nibble-serial add/sub sequencer.
//   state_e   : controller FSM state (IDLE, RUN, DONE)
//   NIB_W     : width of the shared add/sub cell in bits
//   idx_width : bit width needed to count the nibble steps
// Optional feature macro used elsewhere in this slice: SERIAL_ADD_SUB_OVF_EN.
// -----------------------------------------------------------------------------
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;

    // Index width for NIB steps; never narrower than one bit.
    function automatic int idx_width(input int nib);
        if (nib > 1) begin
            return $clog2(nib);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/serial_add_sub_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_sub_ctrl_if
// Request/response bundle of the serial add/sub sequencer.
//   Request : in_valid, in_ready, a, b, sub
//   Response: out_valid, out_ready, result, cout (+ ovf with SERIAL_ADD_SUB_OVF_EN)
// Modports: master = requester/consumer side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface serial_add_sub_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout
`ifdef SERIAL_ADD_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout
`ifdef SERIAL_ADD_SUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/serial_add_sub_ctrl_cell.sv
// -----------------------------------------------------------------------------
// nibble_add_sub_cell
// Combinational 4-bit ripple adder shared by every nibble step.
//   a, b : nibble operands (B already inverted by the controller for subtract)
//   cin  : carry in
//   s    : nibble sum
//   cout : carry out of bit 3
//   c3   : carry into bit 3 (only with SERIAL_ADD_SUB_OVF_EN, for signed overflow)
// -----------------------------------------------------------------------------
module nibble_add_sub_cell
    import serial_add_sub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
    , output logic           c3
`endif
);

    logic [NIB_W:0] c_s;

    // Ripple carry chain; c_s[i] is the carry into bit i.
    always_comb begin
        c_s    = '0;
        s      = '0;
        c_s[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            s[i]     = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c_s[NIB_W];
`ifdef SERIAL_ADD_SUB_OVF_EN
    assign c3   = c_s[NIB_W-1];
`endif

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_sub_ctrl
// WIDTH-bit add/subtract computed one nibble per cycle through a single
// 4-bit cell, least-significant nibble first, with a registered carry.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_add_sub_ctrl_if.slave (valid/ready request and response)
// Optional macro SERIAL_ADD_SUB_OVF_EN adds bus.ovf (signed overflow).
// -----------------------------------------------------------------------------
module serial_add_sub_ctrl
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_sub_ctrl_if.slave  bus
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             sub_q,    sub_d;
    logic             carry_q,  carry_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic             ovf_q,    ovf_d;
    logic             cell_c3_s;
`endif

    logic [NIB_W-1:0] cell_a_s;
    logic [NIB_W-1:0] cell_b_s;
    logic [NIB_W-1:0] cell_s_s;
    logic             cell_cout_s;

    // Select the current nibble; subtract inverts B here, +1 comes from carry.
    always_comb begin
        cell_a_s = a_q[NIB_W*idx_q +: NIB_W];
        cell_b_s = b_q[NIB_W*idx_q +: NIB_W] ^ {NIB_W{sub_q}};
    end

    nibble_add_sub_cell u_cell (
        .a    (cell_a_s),
        .b    (cell_b_s),
        .cin  (carry_q),
        .s    (cell_s_s),
        .cout (cell_cout_s)
`ifdef SERIAL_ADD_SUB_OVF_EN
        , .c3 (cell_c3_s)
`endif
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    carry_d = bus.sub;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[NIB_W*idx_q +: NIB_W] = cell_s_s;
                carry_d = cell_cout_s;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = cell_cout_s;
`ifdef SERIAL_ADD_SUB_OVF_EN
                    // Signed overflow: carry into MSB differs from carry out.
                    ovf_d   = cell_c3_s ^ cell_cout_s;
`endif
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub_ctrl
// Directed self-checking bench for serial_add_sub_ctrl at WIDTH=16.
// Define SERIAL_ADD_SUB_OVF_EN to also check the ovf output.
// -----------------------------------------------------------------------------
module tb_serial_add_sub_ctrl;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   hs_cnt;

    serial_add_sub_ctrl_if #(.WIDTH(16)) bus ();

    serial_add_sub_ctrl #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and count of completed output handshakes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.out_valid && bus.out_ready) begin
            hs_cnt <= hs_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation from IDLE: accept, measure latency, check, consume.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic [15:0] er, input logic ec,
                          input logic eo);
        int cnt;
        bus.a = av; bus.b = bv; bus.sub = sv;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk); @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 32'd4);
        chk({tag, "_result"}, {16'd0, bus.result}, {16'd0, er});
        chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
`ifdef SERIAL_ADD_SUB_OVF_EN
        chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
`else
        if (eo) begin end
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_vld_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ba [3];
        logic [15:0] bb [3];
        logic        bs [3];
        logic [15:0] br [3];
        logic        bc [3];
        int          acc_cyc [3];
        int          guard;
        int          hs0;

        n_tests = 0; n_fail = 0; cyc = 0; hs_cnt = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = 16'h0000; bus.b = 16'h0000;
        bus.sub = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result",    {16'd0, bus.result},    32'd0);
        chk("rst_cout",      {31'd0, bus.cout},      32'd0);
`ifdef SERIAL_ADD_SUB_OVF_EN
        chk("rst_ovf",       {31'd0, bus.ovf},       32'd0);
`endif

        run_op("add_carry", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Backpressure: hold DONE for 5 cycles while poking the request side.
        bus.a = 16'h00A5; bus.b = 16'h0F0F; bus.sub = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 20) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        chk("bp_latency", guard, 32'd4);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = bus.a + 16'h1111;
            bus.sub = ~bus.sub;
            @(posedge clk); @(negedge clk);
            chk("bp_valid",  {31'd0, bus.out_valid}, 32'd1);
            chk("bp_result", {16'd0, bus.result},    32'h0000_0FB4);
            chk("bp_cout",   {31'd0, bus.cout},      32'd0);
            chk("bp_ready",  {31'd0, bus.in_ready},  32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, bus.in_ready},  32'd1);
        chk("bp_result_kept",   {16'd0, bus.result},    32'h0000_0FB4);

        // Reset while RUN is on nibble index 2.
        bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_result",    {16'd0, bus.result},    32'd0);
        chk("mid_rst_cout",      {31'd0, bus.cout},      32'd0);
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Back-to-back: in_valid held high, out_ready held high.
        ba[0] = 16'h0102; bb[0] = 16'h0304; bs[0] = 1'b0; br[0] = 16'h0406; bc[0] = 1'b0;
        ba[1] = 16'h8000; bb[1] = 16'h0001; bs[1] = 1'b1; br[1] = 16'h7FFF; bc[1] = 1'b1;
        ba[2] = 16'hABCD; bb[2] = 16'h5433; bs[2] = 1'b0; br[2] = 16'h0000; bc[2] = 1'b1;
        hs0 = hs_cnt;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a = ba[i]; bus.b = bb[i]; bus.sub = bs[i];
            guard = 0;
            while (!bus.in_ready && guard < 20) begin
                @(posedge clk); @(negedge clk);
                guard++;
            end
            acc_cyc[i] = cyc;
            @(posedge clk); @(negedge clk);
            if (i == 2) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.a = ~ba[i]; bus.b = ~bb[i];
            end
            guard = 0;
            while (!bus.out_valid && guard < 20) begin
                @(posedge clk); @(negedge clk);
                guard++;
            end
            chk("b2b_latency", guard, 32'd4);
            chk("b2b_result", {16'd0, bus.result}, {16'd0, br[i]});
            chk("b2b_cout",   {31'd0, bus.cout},   {31'd0, bc[i]});
            @(posedge clk); @(negedge clk);
        end
        chk("b2b_spacing_1", acc_cyc[1] - acc_cyc[0], 32'd6);
        chk("b2b_spacing_2", acc_cyc[2] - acc_cyc[1], 32'd6);
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("b2b_handshakes", hs_cnt - hs0, 32'd3);
        chk("b2b_idle", {31'd0, bus.in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
